load_store_unit: RTL
====================

# load_store_unit

Sequential load/store unit between the execute stage and the word-addressed `dataMemory`. It takes one byte-addressed RISC-V load or store request at a time and handles alignment and range checks. Sub-word stores use a read-modify-write, and load results are byte/halfword extracted and sign/zero-extended. It drives the memory's combinational-read, level-sensitive-write port from registered outputs only, so `DataMemRW` never glitches.

## Interface
Parameters:
- `MEM_WORDS`, default 32: number of 32-bit words in the data memory. Legal word index is 0..MEM_WORDS-1.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request (high only in IDLE).
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU. BU/HU are legal for loads only.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the low byte or halfword is used for B and H.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  valid with `resp_valid`: misaligned access, illegal funct3, or out of range.
- `mem_addr`  out  32  word index to memory, equal to `req_addr[31:2]`; registered.
- `mem_wdata`  out  32  write data to memory; registered.
- `mem_rw`  out  1  1 = write (maps to `DataMemRW`); registered.
- `mem_rdata`  in  32  combinational read data from memory.

## Operation
- States: IDLE, READ, WRITE, RESP.
- **IDLE**
  - `req_ready`=1. A request is accepted on an edge where `req_valid`=1.
  - On accept, latch `we`, `funct3`, `addr`, `wdata`, and load `mem_addr` with `addr[31:2]`.
- **Error check at accept**: an error is any of:
  - H/HU with `addr[0]`≠0;
  - W with `addr[1:0]`≠0;
  - `funct3` in {011, 110, 111};
  - store with `funct3` in {100, 101};
  - `addr[31:2]` ≥ MEM_WORDS.
  - On error, go to RESP with `resp_err`=1. Memory is never written.
- **Next state after a legal accept**:
  - load goes to READ;
  - SW goes to WRITE, with `mem_wdata`=`wdata` and `mem_rw` set to 1;
  - SB/SH go to READ.
- **READ**
  - `mem_rw`=0. `mem_rdata` is sampled at the end of the cycle.
  - For a load, go to RESP with `resp_rdata` set from `mem_rdata` by lane:
    - B/BU lane = `addr[1:0]`;
    - H/HU lane = `addr[1]`;
    - lane 0 is bits [7:0] (little-endian);
    - B/H sign-extend; BU/HU zero-extend; W passes through.
  - For SB/SH, merge the new byte/halfword into the read word at the lane, load `mem_wdata` with the merged word, set `mem_rw`=1, and go to WRITE.
- **WRITE**
  - `mem_rw`=1 for exactly this one cycle. `mem_addr` and `mem_wdata` are stable for the whole cycle.
  - Clear `mem_rw` at the edge leaving WRITE, then go to RESP.
- **RESP**
  - `resp_valid`=1 for exactly one cycle; then go to IDLE.
  - No response backpressure.
  - `resp_rdata` and `resp_err` hold their values until the next RESP.
- `mem_rw` is 1 only in WRITE. `mem_addr` holds its last value outside accesses.
- A `req_valid` outside IDLE is ignored and not queued. The requester must hold it until it sees `req_ready`.

## Timing
- Latencies, counted as cycles from the accept edge to the `resp_valid` cycle:
  - error: 1 (RESP is the next cycle);
  - load: 2;
  - SW: 2;
  - SB/SH: 3.
- `req_ready` falls the cycle after accept and returns high the cycle after RESP. Throughput is one request per 3 cycles (loads, SW) or 4 cycles (SB/SH).
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_rw`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset asserted mid-operation:
  - `mem_rw` drops immediately (asynchronously) and the transaction is dropped with no response.
  - An SB/SH reset during READ leaves memory unchanged.
  - A reset during WRITE leaves the target word undefined.
- The last address boundary is legal: word MEM_WORDS-1 (byte 0x7C at default) is legal; byte 0x80 gives an error.

## Test plan
- Word store and load: SW addr 0x0C, data 0x11223344. Expect `mem_rw`=1 for one cycle with `mem_addr`=3, then `resp_valid` 2 cycles after accept. LW 0x0C then returns 0x11223344, `resp_err`=0.
- Byte store read-modify-write: after the above, SB addr 0x0D, data 0xAB. Expect READ, WRITE with `mem_wdata`=0x1122AB44, `resp_valid` 3 cycles after accept. LW 0x0C then returns 0x1122AB44.
- Sign and zero extension on word 0x1122AB44 at byte address 0x0C:
  - LB 0x0D returns 0xFFFFFFAB; LBU 0x0D returns 0x000000AB.
  - LH 0x0C returns 0xFFFFAB44; LHU 0x0E returns 0x00001122.
- Errors (each expects `resp_err`=1, `resp_valid` 1 cycle after accept, and `mem_rw` never 1):
  - LH 0x0D;
  - SW 0x0E;
  - LW 0x80;
  - store with funct3=100.
- Handshake: hold `req_valid`=1 continuously with back-to-back LW 0x00 and LW 0x04. Expect the second request accepted only when `req_ready` returns, and responses 3 cycles apart.
- Reset mid-op: SB 0x10 with `Reset` pulsed during READ. Expect no `resp_valid`, all outputs at reset values, and LW 0x10 afterwards returning the original word.

Source files
------------

// File: rtl/load_store_unit.sv
// Sequential RISC-V load/store unit for a word-addressed, combinational-read data memory.
// Handles alignment and range checks, sub-word read-modify-write, and load extension.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rw,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] F3B  = 3'b000;
    localparam logic [2:0] F3H  = 3'b001;
    localparam logic [2:0] F3W  = 3'b010;
    localparam logic [2:0] F3BU = 3'b100;
    localparam logic [2:0] F3HU = 3'b101;

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [15:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_rw_q, mem_rw_d;

    logic        req_err;
    logic [31:0] byte_shift;
    logic [31:0] half_shift;
    logic [31:0] load_data;
    logic [31:0] merged;

    // Request legality is decided entirely from the live request at the accept edge.
    always_comb begin
        req_err = 1'b0;
        unique case (req_funct3)
            F3B, F3BU: req_err = 1'b0;
            F3H, F3HU: req_err = req_addr[0];
            F3W:       req_err = (req_addr[1:0] != 2'b00);
            default:   req_err = 1'b1;
        endcase
        if (req_we && (req_funct3 == F3BU || req_funct3 == F3HU)) begin
            req_err = 1'b1;
        end
        if ({2'b00, req_addr[31:2]} >= MEM_WORDS) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        byte_shift = mem_rdata >> {addr_lo_q, 3'b000};
        half_shift = mem_rdata >> {addr_lo_q[1], 4'b0000};
        load_data  = mem_rdata;
        unique case (funct3_q)
            F3B:     load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
            F3BU:    load_data = {24'h0, byte_shift[7:0]};
            F3H:     load_data = {{16{half_shift[15]}}, half_shift[15:0]};
            F3HU:    load_data = {16'h0, half_shift[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        if (funct3_q == F3H) begin
            merged[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q;
        end else begin
            merged[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rw_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d       = req_we;
                    funct3_d   = req_funct3;
                    addr_lo_d  = req_addr[1:0];
                    wdata_d    = req_wdata[15:0];
                    mem_addr_d = {2'b00, req_addr[31:2]};
                    if (req_err) begin
                        state_d      = StResp;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else if (req_we && req_funct3 == F3W) begin
                        state_d     = StWrite;
                        mem_wdata_d = req_wdata;
                        mem_rw_d    = 1'b1;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                if (we_q) begin
                    state_d     = StWrite;
                    mem_wdata_d = merged;
                    mem_rw_d    = 1'b1;
                end else begin
                    state_d      = StResp;
                    resp_rdata_d = load_data;
                    resp_err_d   = 1'b0;
                end
            end
            StWrite: begin
                state_d      = StResp;
                resp_rdata_d = 32'h0;
                resp_err_d   = 1'b0;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        req_ready_d  = (state_d == StIdle);
        resp_valid_d = (state_d == StResp);
    end

    // Every output is a flop, so the memory write strobe cannot glitch.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            addr_lo_q    <= 2'b00;
            wdata_q      <= 16'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_rw_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_lo_q    <= addr_lo_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rw_q     <= mem_rw_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_rw     = mem_rw_q;

endmodule
